// File: rtl/sevenseg_scan_n.sv
// rtl/sevenseg_scan_n.sv - N-digit seven-segment scan driver with serial binary-to-BCD conversion
module sevenseg_scan_n #(
    parameter int DIGITS       = 4,
    parameter int BIN_W        = 16,
    parameter int REFRESH_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BIN_W-1:0]    value,
    input  logic                load,
    input  logic [1:0]          mode,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   dp_mask,
    output logic                busy,
    output logic                overflow,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int DISP_W = DIGITS * 4;
    // Decimal digits needed for 2**BIN_W-1 is floor(BIN_W*log10(2))+1.
    localparam int NEED_N = (BIN_W * 30103) / 100000 + 1;
    localparam int BCD_N  = (NEED_N > DIGITS) ? NEED_N : DIGITS;
    localparam int BCD_W  = BCD_N * 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int WIDE_W = (BIN_W > DISP_W) ? BIN_W : DISP_W;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COMMIT
    } state_t;

    state_t              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]    bcd_q, bcd_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DISP_W-1:0]   disp_q, disp_d;
    logic                overflow_q, overflow_d;
    logic [REFRESH_BITS-1:0] ref_q, ref_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;

    logic [BCD_W-1:0]    bcd_adj;
    logic [WIDE_W-1:0]   hex_ext;
    logic [DIGITS-1:0]   blank_v;
    logic                all_zero;
    logic [3:0]          nib_sel;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 7'b1000000;
            4'h1: seg_code = 7'b1111001;
            4'h2: seg_code = 7'b0100100;
            4'h3: seg_code = 7'b0110000;
            4'h4: seg_code = 7'b0011001;
            4'h5: seg_code = 7'b0010010;
            4'h6: seg_code = 7'b0000010;
            4'h7: seg_code = 7'b1111000;
            4'h8: seg_code = 7'b0000000;
            4'h9: seg_code = 7'b0010000;
            4'hA: seg_code = 7'b0001000;
            4'hB: seg_code = 7'b0000011;
            4'hC: seg_code = 7'b1000110;
            4'hD: seg_code = 7'b0100001;
            4'hE: seg_code = 7'b0000110;
            default: seg_code = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        hex_ext    = WIDE_W'(value);
        bcd_adj    = bcd_q;
        for (int i = 0; i < BCD_N; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (load && mode == 2'd0) begin
                    bin_d   = value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else if (load && mode == 2'd1) begin
                    disp_d     = hex_ext[DISP_W-1:0];
                    overflow_d = 1'b0;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                disp_d = bcd_q[DISP_W-1:0];
                // Any non-zero BCD nibble above the displayed ones means value >= 10**DIGITS.
                overflow_d = |(bcd_q >> DISP_W);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ref_d = ref_q + REFRESH_BITS'(1);
        idx_d = idx_q;
        if (&ref_q) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        all_zero = 1'b1;
        blank_v  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            all_zero   = all_zero & (disp_q[k*4 +: 4] == 4'd0);
            blank_v[k] = blank_lz & all_zero & (k != 0);
        end

        nib_sel = disp_q[idx_q*4 +: 4];
        an_d    = ~(DIGITS'(1) << idx_q);
        if (mode == 2'd2) begin
            seg_d = SEG_DASH;
        end else if (mode == 2'd3) begin
            seg_d = SEG_BLANK;
        end else if (overflow_q) begin
            seg_d = SEG_DASH;
        end else if (blank_v[idx_q]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_code(nib_sel);
        end
        dp_d = mode[1] ? 1'b1 : ~dp_mask[idx_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            ref_q      <= '0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign overflow = overflow_q;
    assign an       = an_q;
    assign seg      = seg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_n.sv
// tb/tb_sevenseg_scan_n.sv - scoreboard bench for sevenseg_scan_n
module tb_sevenseg_scan_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        load;
    logic [1:0]  mode;
    logic        blank_lz;
    logic [3:0]  dp_mask;
    logic        busy;
    logic        overflow;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    sevenseg_scan_n #(.DIGITS(4), .BIN_W(16), .REFRESH_BITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .load     (load),
        .mode     (mode),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .busy     (busy),
        .overflow (overflow),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] C0   = 7'b1000000;
    localparam logic [6:0] C1   = 7'b1111001;
    localparam logic [6:0] C2   = 7'b0100100;
    localparam logic [6:0] C3   = 7'b0110000;
    localparam logic [6:0] C4   = 7'b0011001;
    localparam logic [6:0] C5   = 7'b0010010;
    localparam logic [6:0] C9   = 7'b0010000;
    localparam logic [6:0] CB   = 7'b0000011;
    localparam logic [6:0] CE   = 7'b0000110;
    localparam logic [6:0] CF   = 7'b0001110;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLK  = 7'h7F;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: whenever the scan presents the anode at the head of the queue, compare seg/dp.
    initial begin
        int   waitn;
        exp_t e;
        waitn = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                waitn = 0;
            end else if (an === exp_q[0].an) begin
                e = exp_q.pop_front();
                checks++;
                if ({seg, dp} !== {e.seg, e.dp}) begin
                    errors++;
                    $display("FAIL %s an=%b: seg=%b dp=%b expected seg=%b dp=%b",
                             e.name, e.an, seg, dp, e.seg, e.dp);
                end
                waitn = 0;
            end else begin
                waitn++;
                if (waitn > 40) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL %s an=%b: never scanned, an=%b", e.name, e.an, an);
                    waitn = 0;
                end
            end
        end
    end

    task automatic push_exp(input string name, input logic [3:0] a, input logic [6:0] s);
        exp_t e;
        e.name = name;
        e.an   = a;
        e.seg  = s;
        e.dp   = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic expect_digits(input string name, input logic [6:0] s3, input logic [6:0] s2,
                                 input logic [6:0] s1, input logic [6:0] s0);
        int n;
        push_exp(name, 4'b0111, s3);
        push_exp(name, 4'b1011, s2);
        push_exp(name, 4'b1101, s1);
        push_exp(name, 4'b1110, s0);
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries left, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [1:0] m);
        value = v;
        mode  = m;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat [5];
        int         n;
        pat[0] = 4'b1101; pat[1] = 4'b1011; pat[2] = 4'b0111; pat[3] = 4'b1110; pat[4] = 4'b1101;

        reset = 1'b1; load = 1'b0; value = '0; mode = 2'd0; blank_lz = 1'b0; dp_mask = '0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);

        // Scan order and 4-cycle dwell, dp lit only on digit 2
        dp_mask = 4'b0100;
        reset   = 1'b0;
        n = 0;
        while (an !== 4'b1101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("scan_sync", an, 4'b1101);
        for (int k = 0; k < 5; k++) begin
            check("scan_an_first", an, pat[k]);
            check("scan_dp", dp, (pat[k] == 4'b1011) ? 0 : 1);
            repeat (3) @(negedge clk);
            check("scan_an_last", an, pat[k]);
            @(negedge clk);
        end
        dp_mask = '0;

        // Decimal 1234 with busy timing
        do_load(16'd1234, 2'd0);
        check("busy_c1", busy, 1);
        repeat (15) @(negedge clk);
        check("busy_c16", busy, 1);
        repeat (2) @(negedge clk);
        check("busy_c18", busy, 0);
        check("ovf_1234", overflow, 0);
        repeat (2) @(negedge clk);
        expect_digits("dec_1234", C1, C2, C3, C4);

        // Leading-zero blanking
        blank_lz = 1'b1;
        do_load(16'd42, 2'd0);
        wait_idle("lz42");
        expect_digits("lz_42", BLK, BLK, C4, C2);
        do_load(16'd0, 2'd0);
        wait_idle("lz0");
        expect_digits("lz_0", BLK, BLK, BLK, C0);
        blank_lz = 1'b0;

        // Overflow shows dashes
        do_load(16'd12345, 2'd0);
        wait_idle("ovf");
        check("ovf_12345", overflow, 1);
        expect_digits("ovf_dash", DASH, DASH, DASH, DASH);

        // Hex load clears overflow, no busy
        do_load(16'hBEEF, 2'd1);
        check("hex_busy_c1", busy, 0);
        @(negedge clk);
        check("hex_busy_c2", busy, 0);
        check("hex_ovf", overflow, 0);
        expect_digits("hex_beef", CB, CE, CE, CF);

        // Live overrides; dp forced off, loads ignored
        dp_mask = 4'hF;
        mode    = 2'd3;
        repeat (2) @(negedge clk);
        expect_digits("mode3_blank", BLK, BLK, BLK, BLK);
        do_load(16'h1234, 2'd3);
        mode = 2'd2;
        repeat (2) @(negedge clk);
        expect_digits("mode2_dash", DASH, DASH, DASH, DASH);
        check("mode2_busy", busy, 0);
        dp_mask = '0;
        mode    = 2'd1;
        repeat (2) @(negedge clk);
        expect_digits("hex_restore", CB, CE, CE, CF);

        do_load(16'd99, 2'd0);
        wait_idle("d99");
        check("ovf_99", overflow, 0);
        expect_digits("dec_0099", C0, C0, C9, C9);

        // Load during conversion ignored
        do_load(16'd5000, 2'd0);
        repeat (4) @(negedge clk);
        do_load(16'd7, 2'd0);
        check("busy_ign", busy, 1);
        wait_idle("d5000");
        check("ovf_5000", overflow, 0);
        expect_digits("dec_5000", C5, C0, C0, C0);

        // Reset mid-conversion
        do_load(16'd1234, 2'd0);
        repeat (7) @(negedge clk);
        check("busy_pre_rst", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_busy", busy, 0);
        check("mrst_an", an, 4'hF);
        check("mrst_seg", seg, 7'h7F);
        check("mrst_dp", dp, 1);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        check("post_rst_busy", busy, 0);
        expect_digits("post_rst", C0, C0, C0, C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
